// File: rtl/ball_pkg.sv
// Shared types and constants for the ball flight block.
// Positions and speeds are signed fixed point, 1 px = 64.
package ball_pkg;

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_flight = 2'd1,
    s_lost   = 2'd2
  } state_e;

  typedef logic signed [16:0] fx_t;

  localparam int FIXED_SHIFT   = 6;
  localparam int INIT_X        = 40;
  localparam int INIT_Y        = 400;
  localparam int BASE_X_SPEED  = 128;
  localparam int BASE_Y_SPEED  = 192;
  localparam int SPEED_STEP    = 64;
  localparam int MAX_LAUNCH    = 4;
  localparam int GRAVITY       = 4;
  localparam int MAX_Y_SPEED   = 512;
  localparam int SCREEN_BOTTOM = 479;

  function automatic fx_t fx_abs(fx_t v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/ball_bounce_latch.sv
// Sticky hit flags collected across a frame.
// Cleared on the physics tick or whenever not in flight.
module ball_bounce_latch
  import ball_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  input  logic hit_left,
  input  logic hit_right,
  input  logic hit_top,
  output logic eff_left,
  output logic eff_right,
  output logic eff_top
);

  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] hits;
  logic [2:0] eff;

  // Merge live pulses with pending flags; clear on tick or idle
  always_comb begin
    hits   = {hit_top, hit_right, hit_left} & {3{en}};
    eff    = pend_q | hits;
    pend_d = (tick || !en) ? 3'b000 : eff;
  end

  assign eff_left  = eff[0];
  assign eff_right = eff[1];
  assign eff_top   = eff[2];

  // Flag register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) pend_q <= 3'b000;
    else       pend_q <= pend_d;
  end

endmodule

// File: rtl/ball_flight.sv
// Ball launch, per-frame motion, bounces, gravity and loss.
// Internal state is 17-bit fixed point with 6 fractional bits.
module ball_flight
  import ball_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               startGame,
  input  logic [2:0]         startSpeed,
  input  logic               startOfFrame,
  input  logic               hit_left,
  input  logic               hit_right,
  input  logic               hit_top,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               ball_active,
  output logic               ball_lost
);

  localparam fx_t INIT_X_FX = fx_t'(INIT_X * 64);
  localparam fx_t INIT_Y_FX = fx_t'(INIT_Y * 64);
  localparam fx_t GRAV_FX   = fx_t'(GRAVITY);
  localparam fx_t MAX_YS_FX = fx_t'(MAX_Y_SPEED);
  localparam fx_t BOTTOM_PX = fx_t'(SCREEN_BOTTOM);

  state_e state_q, state_d;
  fx_t    xpos_q, xpos_d;
  fx_t    ypos_q, ypos_d;
  fx_t    xs_q, xs_d;
  fx_t    ys_q, ys_d;

  logic   in_flight;
  logic   tick;
  logic   eff_left, eff_right, eff_top;
  logic [2:0] s_clamp;
  fx_t    launch_x, launch_y;
  fx_t    xs_upd, ys_upd, ys_grav;
  fx_t    x_new, y_new;
  fx_t    y_px, x_sh, y_sh;
  logic   off_bottom;

  assign in_flight = (state_q == s_flight);
  assign tick      = in_flight && startOfFrame;

  ball_bounce_latch u_latch (
    .clk       (clk),
    .reset     (reset),
    .en        (in_flight),
    .tick      (tick),
    .hit_left  (hit_left),
    .hit_right (hit_right),
    .hit_top   (hit_top),
    .eff_left  (eff_left),
    .eff_right (eff_right),
    .eff_top   (eff_top)
  );

  // Launch speeds and the candidate per-frame physics step
  always_comb begin
    s_clamp  = (int'(startSpeed) > MAX_LAUNCH)
             ? 3'(MAX_LAUNCH) : startSpeed;
    launch_x = fx_t'(BASE_X_SPEED + SPEED_STEP * int'(s_clamp));
    launch_y = fx_t'(BASE_Y_SPEED + SPEED_STEP * int'(s_clamp));
    xs_upd   = xs_q;
    if (eff_right)     xs_upd = -fx_abs(xs_q);
    else if (eff_left) xs_upd = fx_abs(xs_q);
    ys_upd   = eff_top ? fx_abs(ys_q) : ys_q;
    x_new    = xpos_q + xs_upd;
    y_new    = ypos_q + ys_upd;
    ys_grav  = (ys_upd >= MAX_YS_FX - GRAV_FX)
             ? MAX_YS_FX : ys_upd + GRAV_FX;
    y_px     = y_new >>> FIXED_SHIFT;
    off_bottom = (y_px > BOTTOM_PX);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_idle:   if (startGame) state_d = s_flight;
      s_flight: if (tick && off_bottom) state_d = s_lost;
      s_lost:   state_d = s_idle;
      default:  state_d = s_idle;
    endcase
  end

  // Position and speed updates per state
  always_comb begin
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    xs_d   = xs_q;
    ys_d   = ys_q;
    unique case (state_q)
      s_idle: begin
        xpos_d = INIT_X_FX;
        ypos_d = INIT_Y_FX;
        if (startGame) begin
          xs_d = launch_x;
          ys_d = -launch_y;
        end
      end
      s_flight: begin
        if (tick) begin
          xpos_d = x_new;
          ypos_d = y_new;
          xs_d   = xs_upd;
          ys_d   = ys_grav;
        end
      end
      default: begin
        xpos_d = INIT_X_FX;
        ypos_d = INIT_Y_FX;
        xs_d   = '0;
        ys_d   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= s_idle;
      xpos_q  <= INIT_X_FX;
      ypos_q  <= INIT_Y_FX;
      xs_q    <= '0;
      ys_q    <= '0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
    end
  end

  // Outputs decoded from state and position
  always_comb begin
    x_sh        = xpos_q >>> FIXED_SHIFT;
    y_sh        = ypos_q >>> FIXED_SHIFT;
    topLeftX    = x_sh[10:0];
    topLeftY    = y_sh[10:0];
    ball_active = (state_q == s_flight);
    ball_lost   = (state_q == s_lost);
  end

endmodule

// File: tb/tb_ball_flight.sv
// Bench for ball_flight: directed launches, bounces, loss and reset,
// then random games checked against a pixel-physics reference model.
module tb_ball_flight;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               startGame = 1'b0;
  logic [2:0]         startSpeed = 3'd0;
  logic               startOfFrame = 1'b0;
  logic               hit_left = 1'b0;
  logic               hit_right = 1'b0;
  logic               hit_top = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               ball_active;
  logic               ball_lost;

  int errors = 0;
  int checks = 0;

  // reference model: mode 0 idle, 1 flight, 2 lost
  int mode = 0;
  int mx = 40 * 64, my = 400 * 64;
  int mvx = 0, mvy = 0;
  bit pl = 0, pr = 0, pt = 0;

  ball_flight dut (
    .clk          (clk),
    .reset        (reset),
    .startGame    (startGame),
    .startSpeed   (startSpeed),
    .startOfFrame (startOfFrame),
    .hit_left     (hit_left),
    .hit_right    (hit_right),
    .hit_top      (hit_top),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .ball_active  (ball_active),
    .ball_lost    (ball_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic model(bit r, bit sg, int ss, bit sf,
                       bit hl, bit hr, bit ht);
    int s;
    if (r) begin
      mode = 0; mx = 2560; my = 25600;
      mvx = 0; mvy = 0; pl = 0; pr = 0; pt = 0;
    end else if (mode == 0) begin
      if (sg) begin
        s = ss > 4 ? 4 : ss;
        mvx = 128 + 64 * s;
        mvy = -(192 + 64 * s);
        mode = 1;
      end
    end else if (mode == 1) begin
      pl |= hl; pr |= hr; pt |= ht;
      if (sf) begin
        if (pr)      mvx = -iabs(mvx);
        else if (pl) mvx = iabs(mvx);
        if (pt)      mvy = iabs(mvy);
        mx += mvx;
        my += mvy;
        mvy = (mvy + 4 > 512) ? 512 : mvy + 4;
        pl = 0; pr = 0; pt = 0;
        if ((my >>> 6) > 479) mode = 2;
      end
    end else begin
      mode = 0; mx = 2560; my = 25600;
      mvx = 0; mvy = 0;
    end
  endtask

  task automatic drive(bit r, bit sg, int ss, bit sf,
                       bit hl, bit hr, bit ht);
    reset = r; startGame = sg; startSpeed = 3'(ss);
    startOfFrame = sf;
    hit_left = hl; hit_right = hr; hit_top = ht;
    @(posedge clk);
    #1;
    model(r, sg, ss, sf, hl, hr, ht);
    reset = 0; startGame = 0; startOfFrame = 0;
    hit_left = 0; hit_right = 0; hit_top = 0;
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".x"}, int'(topLeftX), mx >>> 6);
    chk({tag, ".y"}, int'(topLeftY), my >>> 6);
    chk({tag, ".act"}, int'(ball_active), int'(mode == 1));
    chk({tag, ".lost"}, int'(ball_lost), int'(mode == 2));
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic frame(); drive(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic launch(int ss); drive(0, 1, ss, 0, 0, 0, 0); endtask
  task automatic rst(); drive(1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    int f;
    bit hl, hr, ht;

    // reset state
    rst();
    chk("rst.x", int'(topLeftX), 40);
    chk("rst.y", int'(topLeftY), 400);
    chk("rst.act", int'(ball_active), 0);
    chk("rst.lost", int'(ball_lost), 0);

    // hits in idle are ignored; slowest launch
    drive(0, 0, 0, 0, 1, 1, 1);
    launch(0);
    chk("l0.act", int'(ball_active), 1);
    chk("l0.x0", int'(topLeftX), 40);
    idle();
    frame();
    chk("l0.x", int'(topLeftX), 42);
    chk("l0.y", int'(topLeftY), 397);
    chk("l0.ys", int'($signed(dut.ys_q)), -188);
    chk_all("l0");

    // launch coincident with a frame: no motion that frame
    rst();
    drive(0, 1, 4, 1, 0, 0, 0);
    chk("l4.nomove.x", int'(topLeftX), 40);
    chk("l4.nomove.y", int'(topLeftY), 400);
    frame();
    chk("l4.x", int'(topLeftX), 46);
    chk("l4.y", int'(topLeftY), 393);

    // startSpeed 7 clamps to 4; startGame in flight ignored
    rst();
    launch(7);
    launch(0);
    frame();
    chk("l7.x", int'(topLeftX), 46);
    chk("l7.y", int'(topLeftY), 393);
    chk_all("l7");

    // hit_right twice in one frame reverses X once
    rst();
    launch(0);
    frame();
    drive(0, 0, 0, 0, 0, 1, 0);
    idle();
    drive(0, 0, 0, 0, 0, 1, 0);
    frame();
    chk("hr.x", int'(topLeftX), 40);
    frame();
    chk("hr.x2", int'(topLeftX), 38);
    chk_all("hr");

    // left+right both pending: right wins; coincident top
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 1);
    chk_all("lrt");

    // reset mid-flight, then normal relaunch
    frame();
    rst();
    chk("mr.x", int'(topLeftX), 40);
    chk("mr.y", int'(topLeftY), 400);
    chk("mr.act", int'(ball_active), 0);
    launch(2);
    frame();
    chk("mr.x2", int'(topLeftX), 44);
    chk("mr.y2", int'(topLeftY), 395);

    // random games played to loss against the model
    for (int g = 0; g < 4; g++) begin
      rst();
      launch(int'($urandom_range(0, 7)));
      for (f = 0; f < 400 && mode == 1; f++) begin
        for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
          hl = (mx >>> 6) < 20 || $urandom_range(0, 15) == 0;
          hr = (mx >>> 6) > 560 || $urandom_range(0, 15) == 0;
          ht = (my >>> 6) < 20 || $urandom_range(0, 15) == 0;
          drive(0, 0, 0, 0, hl, hr, ht);
        end
        hl = $urandom_range(0, 7) == 0;
        hr = $urandom_range(0, 7) == 0;
        ht = $urandom_range(0, 7) == 0;
        drive(0, 0, 0, 1, hl, hr, ht);
        chk_all($sformatf("g%0d.f%0d", g, f));
      end
      chk($sformatf("g%0d.lost", g), int'(ball_lost), 1);
      idle();
      chk($sformatf("g%0d.lost1", g), int'(ball_lost), 0);
      chk($sformatf("g%0d.ix", g), int'(topLeftX), 40);
      chk($sformatf("g%0d.iy", g), int'(topLeftY), 400);
      chk_all($sformatf("g%0d.idle", g));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_flight.md
BALL_FLIGHT -- requirements
Module: ball_flight

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port `startGame`, input, 1 bit: one-cycle launch pulse from the launch FSM.
REQ-004 SHALL have port `startSpeed`, input, 3 bits: launch strength 0..4, sampled on `startGame`.
REQ-005 SHALL have port `startOfFrame`, input, 1 bit: one-cycle pulse per video frame; the physics tick.
REQ-006 SHALL have ports `hit_left`, `hit_right`, `hit_top`, inputs, 1 bit each: collision pulses, arriving anywhere within a frame.
REQ-007 SHALL have ports `topLeftX` and `topLeftY`, outputs, 11 bits signed each: ball pixel position.
REQ-008 SHALL have port `ball_active`, output, 1 bit: high while the ball is in flight.
REQ-009 SHALL have port `ball_lost`, output, 1 bit: one-cycle pulse when the ball leaves the screen bottom.

Function
REQ-010 SHALL hold position and speed as signed 17-bit fixed point with 6 fractional bits (1 px = 64).
REQ-011 SHALL drive `topLeftX`/`topLeftY` as the internal position arithmetically shifted right by 6.
REQ-012 SHALL implement states s_idle, s_flight, s_lost.
REQ-013 s_idle SHALL hold position at INIT_X=40 px, INIT_Y=400 px with `ball_active`=0.
REQ-014 In s_idle, a `startGame` pulse SHALL load speeds and move to s_flight on the next cycle.
- Xspeed = 128 + 64*S.
- Yspeed = -(192 + 64*S).
- S = min(startSpeed, 4); values 5..7 SHALL clamp to 4.
REQ-015 `startGame` outside s_idle SHALL be ignored.
REQ-016 If `startGame` and `startOfFrame` coincide in s_idle, the launch SHALL take effect and no motion SHALL occur on that frame.
REQ-017 In s_flight, each of `hit_left`/`hit_right`/`hit_top` SHALL set a sticky pending flag.
REQ-018 On `startOfFrame` in s_flight, the block SHALL apply, in order:
- (a) hit_left → Xspeed = +|Xspeed|; hit_right → Xspeed = -|Xspeed|; hit_top → Yspeed = +|Yspeed|.
- (b) position += updated speed.
- (c) Yspeed += GRAVITY (4), saturating at MAX_Y_SPEED (+512).
- (d) clear all pending flags.
REQ-019 If hit_left and hit_right are both pending, hit_right SHALL win.
REQ-020 A hit pulse coincident with `startOfFrame` SHALL be applied in that same update.
REQ-021 Updated outputs SHALL be visible one cycle after the `startOfFrame` edge.
REQ-022 When the updated Y position exceeds SCREEN_BOTTOM (479 px), the next state SHALL be s_lost.
REQ-023 s_lost SHALL last exactly one cycle, assert `ball_lost`=1, restore the initial position, clear speeds and flags, then go to s_idle.
REQ-024 `ball_active` SHALL be 1 only in s_flight.
REQ-025 Hit inputs SHALL be ignored in s_idle and s_lost.

Reset
REQ-026 `reset`=1 SHALL force, on the next clock edge, regardless of state (including mid-flight):
- state s_idle;
- position at INIT_X/INIT_Y, so `topLeftX`=40 and `topLeftY`=400;
- speeds 0;
- pending flags cleared;
- `ball_active`=0 and `ball_lost`=0.
REQ-027 `reset` SHALL take priority over every other input.

Structure
REQ-028 Package ball_pkg SHALL hold:
- the state enum;
- FIXED_SHIFT=6, INIT_X, INIT_Y;
- BASE_X_SPEED=128, BASE_Y_SPEED=192, SPEED_STEP=64, MAX_LAUNCH=4;
- GRAVITY=4, MAX_Y_SPEED=512, SCREEN_BOTTOM=479.
REQ-029 Sub-module ball_bounce_latch SHALL own the three sticky hit flags and their clear-on-tick logic; all other logic SHALL be in ball_flight.

Verification
REQ-030 Pulse `reset` → `topLeftX`=40, `topLeftY`=400, `ball_active`=0, `ball_lost`=0.
REQ-031 `startSpeed`=0, `startGame`, then one `startOfFrame` → X=42, Y=397; internal Yspeed=-188.
REQ-032 `startSpeed`=4, launch, one frame → X=46, Y=393.
REQ-033 `startSpeed`=7 → identical results to `startSpeed`=4 (clamp).
REQ-034 In flight with Xspeed=+128: pulse `hit_right` mid-frame, then `startOfFrame` → X decreases by 2 px; a second `hit_right` in the same frame has no additional effect.
REQ-035 Run frames until Y > 479 → `ball_lost` high exactly 1 cycle, then s_idle with X=40, Y=400.
REQ-036 Assert `reset` mid-flight → X=40, Y=400, `ball_active`=0 on the next cycle; a later `startGame` relaunches normally.
